timer_ctrl_master: RTL

Avalon-MM master that drives the 16-bit-data, 64-bit-counter interval timer slave on behalf of hardware clients, so no CPU is needed. It accepts commands to program-and-start, stop, snapshot and clear. It also services the timer interrupt autonomously by clearing the timeout status and counting events. It sits between a local command source (e.g. a frame-pacing or DMA scheduler) and the timer's s1 slave port.

---
 rtl/timer_ctrl_master.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs, stops, snapshots and clears the interval timer
// slave on behalf of hardware clients, and services its timeout interrupt.
module timer_ctrl_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_irq_en,
  output logic [3:0]  tmr_address,
  output logic        tmr_chipselect,
  output logic        tmr_write_n,
  output logic [15:0] tmr_writedata,
  input  logic [15:0] tmr_readdata,
  input  logic        tmr_irq,
  output logic [63:0] snap_value,
  output logic        snap_valid,
  output logic        event_pulse,
  output logic [31:0] event_count
);

  typedef enum logic [3:0] {
    IDLE, PROG, START, STOP, SNAP_W, SNAP_R, SNAP_CAP, CLEAR, IRQ_CLR
  } state_t;

  localparam logic [1:0] OP_PROG  = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_SNAP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  state_t      state;
  logic [1:0]  idx;
  logic [63:0] period_q;
  logic        cont_q;
  logic        irq_en_q;
  logic [47:0] shadow;
  logic        accept;

  function automatic logic [15:0] period_half(input logic [63:0] p, input logic [1:0] k);
    case (k)
      2'd0:    return p[15:0];
      2'd1:    return p[31:16];
      2'd2:    return p[47:32];
      default: return p[63:48];
    endcase
  endfunction

  // A pending interrupt in IDLE wins over any command, so ready is withheld.
  assign cmd_ready = reset_n && (state == IDLE) && !tmr_irq;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (accept) begin
      period_q <= cmd_period;
      cont_q   <= cmd_continuous;
      irq_en_q <= cmd_irq_en;
    end
    // Read data trails the address by one cycle: halfword idx-1 arrives now.
    if (state == SNAP_R) begin
      case (idx)
        2'd1:    shadow[15:0]  <= tmr_readdata;
        2'd2:    shadow[31:16] <= tmr_readdata;
        2'd3:    shadow[47:32] <= tmr_readdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= 2'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 4'd0;
      tmr_writedata  <= 16'd0;
      snap_value     <= 64'd0;
      snap_valid     <= 1'b0;
      event_pulse    <= 1'b0;
      event_count    <= 32'd0;
    end else begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 4'd0;
      tmr_writedata  <= 16'd0;
      snap_valid     <= 1'b0;
      event_pulse    <= 1'b0;
      case (state)
        IDLE: begin
          if (tmr_irq) begin
            state          <= IRQ_CLR;
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            event_pulse    <= 1'b1;
          end else if (cmd_valid) begin
            tmr_chipselect <= 1'b1;
            tmr_write_n    <= 1'b0;
            case (cmd_op)
              OP_PROG: begin
                state         <= PROG;
                idx           <= 2'd0;
                tmr_address   <= 4'd2;
                tmr_writedata <= cmd_period[15:0];
              end
              OP_STOP: begin
                state         <= STOP;
                tmr_address   <= 4'd1;
                tmr_writedata <= 16'h0008;
              end
              OP_SNAP: begin
                state       <= SNAP_W;
                tmr_address <= 4'd6;
              end
              default: state <= CLEAR;
            endcase
          end
        end
        PROG: begin
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          if (idx == 2'd3) begin
            state         <= START;
            tmr_address   <= 4'd1;
            tmr_writedata <= {12'd0, 1'b0, 1'b1, cont_q, irq_en_q};
          end else begin
            idx           <= idx + 2'd1;
            tmr_address   <= 4'd3 + {2'b00, idx};
            tmr_writedata <= period_half(period_q, idx + 2'd1);
          end
        end
        SNAP_W: begin
          state          <= SNAP_R;
          idx            <= 2'd0;
          tmr_chipselect <= 1'b1;
          tmr_address    <= 4'd6;
        end
        SNAP_R: begin
          if (idx == 2'd3) begin
            state <= SNAP_CAP;
          end else begin
            idx            <= idx + 2'd1;
            tmr_chipselect <= 1'b1;
            tmr_address    <= 4'd7 + {2'b00, idx};
          end
        end
        SNAP_CAP: begin
          state      <= IDLE;
          snap_value <= {tmr_readdata, shadow};
          snap_valid <= 1'b1;
        end
        CLEAR: begin
          state       <= IDLE;
          event_count <= 32'd0;
        end
        IRQ_CLR: begin
          state       <= IDLE;
          event_count <= event_count + 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
